uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit-side byte buffer placed directly upstream of `uart_tx`. It accepts bytes from a producer through a valid-only write port, stores up to DEPTH of them, and drains them one at a time into `uart_tx` using its `tx_start`/`tx_data`/`tx_busy` handshake. Bytes leave in the order they were written, with no gaps beyond those the handshake needs. `uart_top` instantiates it between the system write interface and `tx_inst`.

## Interface
- DEPTH, 16: number of entries; must be a power of 2 and at least 2.
- DATA_W, 8: byte width; must match `uart_tx`.
- GUARD, 4: number of cycles to wait for `tx_busy` to rise after a launch before the byte is treated as taken.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- wr_en  in  1  write strobe; one byte is written per cycle when high.
- wr_data  in  DATA_W  byte to enqueue.
- full  out  1  high when level == DEPTH.
- empty  out  1  high when level == 0.
- level  out  $clog2(DEPTH)+1  number of stored entries.
- tx_busy  in  1  busy flag from `uart_tx`.
- tx_start  out  1  single-cycle launch pulse to `uart_tx`.
- tx_data  out  DATA_W  byte presented to `uart_tx`; held stable from launch until the next launch.
- ovf  out  1  sticky overflow flag (present only with the macro enabled).
- ovf_clr  in  1  clears `ovf` (present only with the macro enabled).

## Operation
- Storage is a circular buffer.
  - `wr_ptr` and `rd_ptr` are each $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `level` is maintained as a counter, not derived from the pointers.
- Write side:
  - A write is accepted when `wr_en` is high and `full` is low. The byte is stored at `wr_ptr`, `wr_ptr` increments and `level` increments.
  - `wr_en` while `full` is high drops the byte and leaves the state unchanged. This holds even if a pop occurs in the same cycle.
- Drain FSM, states IDLE, WAIT_BUSY, WAIT_DONE:
  - IDLE: if `level` > 0 and `tx_busy` is low, pop one entry. On the pop, `tx_data` <= mem[rd_ptr], `rd_ptr` increments, `tx_start` <= 1, and the FSM goes to WAIT_BUSY with the guard counter cleared.
  - WAIT_BUSY: on `tx_busy` high go to WAIT_DONE. Otherwise increment the guard counter; when it reaches GUARD-1 go to IDLE.
  - WAIT_DONE: on `tx_busy` low go to IDLE.
- A simultaneous accepted write and pop leaves `level` unchanged and advances both pointers.
- `tx_start` is registered and high for exactly one cycle per pop. It is never asserted outside the cycle after IDLE.

## Timing
- Reset values (rst low at an edge):
  - `wr_ptr`, `rd_ptr` and `level` = 0.
  - `empty` = 1, `full` = 0.
  - `tx_start` = 0, `tx_data` = 0.
  - `ovf` = 0.
  - FSM = IDLE.
  - Memory contents are not reset.
- Reset in the middle of a frame abandons all stored bytes. `uart_tx` shares the same reset.
- `full`, `empty` and `level` update at the edge after the write or pop.
- Latency with an empty FIFO, idle FSM and `tx_busy` low:
  - Write at edge N.
  - Pop and `tx_start` register at edge N+1.
  - `tx_start` is high during cycle N+1..N+2.
- Back-to-back bytes: the next pop happens at the first edge where the FSM is in IDLE with `tx_busy` low, which is one cycle after `tx_busy` falls.
- Wrap-around: pointers pass DEPTH-1 → 0 with no bubble.

## Configuration
- `UART_TX_FIFO_OVF_EN` defined:
  - `ovf` is set at the edge after any `wr_en` with `full` high, and stays set.
  - `ovf_clr` high clears it at the next edge.
  - A set and a clear in the same cycle leave `ovf` at 1.
- Macro undefined: the `ovf` and `ovf_clr` ports are absent and dropped writes are silent.

## Structure
- A shared package `uart_pkg` holds:
  - the drain FSM state enum `tx_fifo_state_t`;
  - the default DATA_W constant `UART_DATA_W` = 8, also used by `uart_tx`/`uart_rx`.
- One sub-module, `uart_fifo_mem`: a simple dual-port register array with a synchronous write and a combinational read at `rd_ptr`.
- Pointer, level and FSM logic stay in `uart_tx_fifo`.

## Test plan
- Reset, then write 0xA5 with `tx_busy` held low → `tx_start` pulses 2 cycles after the write with `tx_data` = 0xA5. `empty` = 1 again after the pop.
- Write 0x11, 0x22, 0x33 back-to-back against a `uart_tx` model whose busy lasts 10 cycles → exactly 3 `tx_start` pulses in order 0x11, 0x22, 0x33, each one cycle after busy falls.
- Hold `tx_busy` high and write 17 bytes with DEPTH = 16 → `full` = 1 and `level` = 16. The 17th byte is dropped and `ovf` = 1 with the macro enabled. `ovf_clr` then gives `ovf` = 0.
- Fill to 16, then release `tx_busy` while writing one byte in the same cycle as the first pop → that write is dropped and exactly 16 bytes are sent.
- `tx_busy` is never asserted after a launch → the FSM returns to IDLE after GUARD = 4 cycles and the next byte launches.
- Assert `rst` low while in WAIT_DONE with 5 entries queued → the next cycle shows `level` = 0, `empty` = 1, `tx_start` = 0, FSM = IDLE, and no further pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width and the TX FIFO drain FSM states.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        TXF_IDLE      = 2'd0,
        TXF_WAIT_BUSY = 2'd1,
        TXF_WAIT_DONE = 2'd2
    } tx_fifo_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: synchronous write, combinational read.
module uart_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO that drains into uart_tx via tx_start/tx_data/tx_busy.
// Define UART_TX_FIFO_OVF_EN to add the sticky ovf flag and ovf_clr input.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W,
    parameter int GUARD  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     tx_busy,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        tx_data
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic                     ovf,
    input  logic                     ovf_clr
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(GUARD + 1);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [GW-1:0]     guard_q, guard_d;
    tx_fifo_state_t    state_q, state_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [DATA_W-1:0] rd_data;
    logic              full_w;
    logic              accept;
    logic              pop;

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign full_w = (level_q == LW'(DEPTH));

    always_comb begin
        accept     = wr_en && !full_w;
        pop        = (state_q == TXF_IDLE) && (level_q != '0) && !tx_busy;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        state_d    = state_q;
        guard_d    = guard_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            tx_start_d = 1'b1;
            tx_data_d  = rd_data;
        end

        unique case ({accept, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Guard timeout covers a uart_tx that never raises busy.
        unique case (state_q)
            TXF_IDLE: begin
                if (pop) begin
                    state_d = TXF_WAIT_BUSY;
                    guard_d = '0;
                end
            end
            TXF_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = TXF_WAIT_DONE;
                end else begin
                    guard_d = guard_q + GW'(1);
                    if (guard_d == GW'(GUARD - 1)) begin
                        state_d = TXF_IDLE;
                    end
                end
            end
            TXF_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = TXF_IDLE;
                end
            end
            default: state_d = TXF_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            guard_q    <= '0;
            state_q    <= TXF_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            guard_q    <= guard_d;
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q, ovf_d;

    // A drop in the same cycle as a clear wins.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (wr_en && full_w) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign full     = full_w;
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: vector table plus multi-cycle sequences.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       full, empty;
    logic [4:0] level;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy_drv = 1'b0;
    logic       model_en = 1'b0;
    int         mcnt = 0;
`ifdef UART_TX_FIFO_OVF_EN
    logic       ovf;
    logic       ovf_clr = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mon_n = 0;
    logic [7:0] mon_data [256];
    int         mon_cyc [256];

    uart_tx_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
`endif
    );

    always #5 clk = ~clk;

    assign tx_busy = model_en ? (mcnt != 0) : busy_drv;

    always @(posedge clk) cyc = cyc + 1;

    // uart_tx stand-in: busy for 10 cycles after each launch
    always @(negedge clk) begin
        if (!model_en) mcnt = 0;
        else if (mcnt != 0) mcnt = mcnt - 1;
        else if (tx_start) mcnt = 10;
    end

    always @(negedge clk) begin
        if (tx_start && mon_n < 256) begin
            mon_data[mon_n] = tx_data;
            mon_cyc[mon_n]  = cyc;
            mon_n = mon_n + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       busy;
        logic       ts;
        logic [7:0] td;
        logic [4:0] lvl;
        logic       emp;
    } vec_t;

    vec_t vecs [25];
    int base;

    initial begin
        vecs[0]  = '{1, 8'hA5, 0, 0, 8'h00, 1, 0};
        vecs[1]  = '{0, 8'h00, 0, 1, 8'hA5, 0, 1};
        vecs[2]  = '{0, 8'h00, 0, 0, 8'hA5, 0, 1};
        vecs[3]  = '{0, 8'h00, 0, 0, 8'hA5, 0, 1};
        vecs[4]  = '{0, 8'h00, 0, 0, 8'hA5, 0, 1};
        vecs[5]  = '{1, 8'h3C, 0, 0, 8'hA5, 1, 0};
        vecs[6]  = '{1, 8'hC3, 0, 1, 8'h3C, 1, 0};
        vecs[7]  = '{0, 8'h00, 0, 0, 8'h3C, 1, 0};
        vecs[8]  = '{0, 8'h00, 0, 0, 8'h3C, 1, 0};
        vecs[9]  = '{0, 8'h00, 0, 0, 8'h3C, 1, 0};
        vecs[10] = '{0, 8'h00, 0, 1, 8'hC3, 0, 1};
        vecs[11] = '{0, 8'h00, 0, 0, 8'hC3, 0, 1};
        vecs[12] = '{0, 8'h00, 0, 0, 8'hC3, 0, 1};
        vecs[13] = '{0, 8'h00, 0, 0, 8'hC3, 0, 1};
        vecs[14] = '{0, 8'h00, 0, 0, 8'hC3, 0, 1};
        vecs[15] = '{1, 8'h5A, 1, 0, 8'hC3, 1, 0};
        vecs[16] = '{0, 8'h00, 1, 0, 8'hC3, 1, 0};
        vecs[17] = '{0, 8'h00, 0, 1, 8'h5A, 0, 1};
        vecs[18] = '{0, 8'h00, 1, 0, 8'h5A, 0, 1};
        vecs[19] = '{1, 8'h66, 1, 0, 8'h5A, 1, 0};
        vecs[20] = '{0, 8'h00, 0, 0, 8'h5A, 1, 0};
        vecs[21] = '{0, 8'h00, 0, 1, 8'h66, 0, 1};
        vecs[22] = '{0, 8'h00, 0, 0, 8'h66, 0, 1};
        vecs[23] = '{0, 8'h00, 0, 0, 8'h66, 0, 1};
        vecs[24] = '{0, 8'h00, 0, 0, 8'h66, 0, 1};

        step();
        step();
        chk("rst_level", int'(level), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_tx_data", int'(tx_data), 0);
`ifdef UART_TX_FIFO_OVF_EN
        chk("rst_ovf", int'(ovf), 0);
`endif
        rst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            wr_en    = vecs[i].wr;
            wr_data  = vecs[i].wd;
            busy_drv = vecs[i].busy;
            step();
            chk($sformatf("v%0d_tx_start", i), int'(tx_start), int'(vecs[i].ts));
            chk($sformatf("v%0d_tx_data", i), int'(tx_data), int'(vecs[i].td));
            chk($sformatf("v%0d_level", i), int'(level), int'(vecs[i].lvl));
            chk($sformatf("v%0d_empty", i), int'(empty), int'(vecs[i].emp));
        end
        wr_en = 1'b0;
        busy_drv = 1'b0;

        // Three bytes against the 10-cycle busy model
        model_en = 1'b1;
        base = mon_n;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h11 * (i + 1));
            step();
        end
        wr_en = 1'b0;
        repeat (50) step();
        chk("b2b_count", mon_n - base, 3);
        chk("b2b_d0", int'(mon_data[base]), 8'h11);
        chk("b2b_d1", int'(mon_data[base + 1]), 8'h22);
        chk("b2b_d2", int'(mon_data[base + 2]), 8'h33);
        chk("b2b_gap1", mon_cyc[base + 1] - mon_cyc[base], 12);
        chk("b2b_gap2", mon_cyc[base + 2] - mon_cyc[base + 1], 12);
        model_en = 1'b0;
        step();

        // Fill with busy high; 17th byte is dropped
        busy_drv = 1'b1;
        base = mon_n;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h40 + i);
            step();
        end
        wr_en = 1'b0;
        chk("fill_level", int'(level), 16);
        chk("fill_full", int'(full), 1);
        chk("fill_empty", int'(empty), 0);
        chk("fill_no_launch", mon_n - base, 0);
`ifdef UART_TX_FIFO_OVF_EN
        chk("ovf_set", int'(ovf), 1);
        wr_en = 1'b1;
        ovf_clr = 1'b1;
        step();
        chk("ovf_set_and_clr", int'(ovf), 1);
        wr_en = 1'b0;
        step();
        chk("ovf_clr", int'(ovf), 0);
        ovf_clr = 1'b0;
        chk("ovf_level", int'(level), 16);
`endif

        // Release busy with a write in the same cycle as the first pop
        busy_drv = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        chk("pop_full_level", int'(level), 15);
        chk("pop_full_full", int'(full), 0);
        chk("pop_full_tx_start", int'(tx_start), 1);
        chk("pop_full_tx_data", int'(tx_data), 8'h40);
        repeat (80) step();
        chk("drain_count", mon_n - base, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_d%0d", i), int'(mon_data[base + i]), 8'h40 + i);
        end
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("drain_gap%0d", i), mon_cyc[base + i] - mon_cyc[base + i - 1], 4);
        end
        chk("drain_empty", int'(empty), 1);

        // Reset while in WAIT_DONE with 5 entries queued
        model_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h90 + i);
            step();
        end
        wr_en = 1'b0;
        chk("pre_rst_level", int'(level), 5);
        chk("pre_rst_state", int'(dut.state_q), int'(TXF_WAIT_DONE));
        rst = 1'b0;
        model_en = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_full", int'(full), 0);
        chk("mid_rst_tx_start", int'(tx_start), 0);
        chk("mid_rst_state", int'(dut.state_q), int'(TXF_IDLE));
        base = mon_n;
        repeat (30) step();
        chk("post_rst_pulses", mon_n - base, 0);
        chk("post_rst_level", int'(level), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
